// File: rtl/pokey_pkg.sv
// pokey_pkg: shared constants and FSM state encoding for the POKEY serial output block.
//   DATA_BITS / START_BITS / STOP_BITS : frame geometry (8N1)
//   IDX_W / IDX_LAST                   : data-bit index width and last index
//   ser_state_e                        : IDLE, START, DATA, STOP
package pokey_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned START_BITS = 1;
   localparam int unsigned STOP_BITS  = 1;
   localparam int unsigned FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
   localparam int unsigned IDX_W      = 3;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } ser_state_e;

endpackage

// File: rtl/pokey_serout_if.sv
// pokey_serout_if: CPU-side register interface of the serial output block.
//   wr   : SEROUT write strobe (one enabled cycle)
//   D    : write data
//   odn  : output-data-needed pulse (IRQ source)
//   oc   : output complete level
//   busy : transmitter not idle
interface pokey_serout_if;
   import pokey_pkg::*;

   logic                 wr;
   logic [DATA_BITS-1:0] D;
   logic                 odn;
   logic                 oc;
   logic                 busy;

   modport master (output wr, D, input odn, oc, busy);
   modport slave  (input wr, D, output odn, oc, busy);

endinterface

// File: rtl/pokey_serout.sv
// pokey_serout: POKEY SEROUT holding register + 8N1 shifter, LSB first.
// All state updates on the falling edge of clk, qualified by enn; rst is
// synchronous, active-high and overrides enn.
//   clk, rst, enn : clock, reset, clock enable
//   bus (slave)   : wr/D in, odn/oc/busy out (all registered)
//   bit_tick      : bit-period pulse from the baud channel
//   brk           : force sout low without disturbing the frame
//   two_tone, tone1, tone2 : two-tone FSK controls
//   sout          : serial output, idle high (registered)
// Optional build macro: POKEY_TWO_TONE_EN adds the tone flop; without it the
// two-tone inputs are accepted but have no effect.
module pokey_serout
   import pokey_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          enn,
   pokey_serout_if.slave bus,
   input  logic          bit_tick,
   input  logic          brk,
   input  logic          two_tone,
   input  logic          tone1,
   input  logic          tone2,
   output logic          sout
);

   ser_state_e           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 sout_q, sout_d;
   logic                 odn_q, odn_d;
   logic                 oc_q, oc_d;
   logic                 busy_q, busy_d;
   logic                 xfer;
   logic                 level_d;

`ifdef POKEY_TWO_TONE_EN
   logic                 tone_q, tone_d;
`else
   logic                 unused_tone;
   assign unused_tone = ^{two_tone, tone1, tone2};
`endif

   // Next-state, holding register and output levels for the next enabled edge
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      sout_d      = sout_q;
      odn_d       = odn_q;
      oc_d        = oc_q;
      busy_d      = busy_q;
      xfer        = 1'b0;
      level_d     = 1'b1;
`ifdef POKEY_TWO_TONE_EN
      tone_d      = tone_q;
`endif

      if (enn) begin
         // Load the shifter from IDLE, or straight from a finishing stop bit
         xfer = hold_full_q &&
                ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_tick));

         if (bit_tick) begin
            case (state_q)
               ST_START: begin
                  state_d = ST_DATA;
                  idx_d   = '0;
               end
               ST_DATA: begin
                  if (idx_q == IDX_LAST) state_d = ST_STOP;
                  else                   idx_d   = idx_q + IDX_W'(1);
               end
               ST_STOP: state_d = ST_IDLE;
               default: ;
            endcase
         end

         if (xfer) begin
            state_d = ST_START;
            shift_d = hold_q;
            idx_d   = '0;
         end

         // A coincident write refills the holding register after the shifter took the old byte
         if (bus.wr) begin
            hold_d      = bus.D;
            hold_full_d = 1'b1;
         end else if (xfer) begin
            hold_full_d = 1'b0;
         end

         odn_d = xfer;

         case (state_d)
            ST_START: level_d = 1'b0;
            ST_DATA:  level_d = shift_d[idx_d];
            default:  level_d = 1'b1;
         endcase

`ifdef POKEY_TWO_TONE_EN
         // Mark bits toggle on tone1, space bits on tone2
         tone_d = tone_q ^ (level_d ? tone1 : tone2);
         sout_d = brk ? 1'b0 : (two_tone ? tone_d : level_d);
`else
         sout_d = ~brk & level_d;
`endif

         oc_d   = (state_d == ST_IDLE) && !hold_full_d;
         busy_d = (state_d != ST_IDLE);
      end
   end

   // State and output registers
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         sout_q      <= 1'b1;
         odn_q       <= 1'b0;
         oc_q        <= 1'b1;
         busy_q      <= 1'b0;
`ifdef POKEY_TWO_TONE_EN
         tone_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         sout_q      <= sout_d;
         odn_q       <= odn_d;
         oc_q        <= oc_d;
         busy_q      <= busy_d;
`ifdef POKEY_TWO_TONE_EN
         tone_q      <= tone_d;
`endif
      end
   end

   assign sout     = sout_q;
   assign bus.odn  = odn_q;
   assign bus.oc   = oc_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_pokey_serout.sv
// tb_pokey_serout: directed stimulus for pokey_serout with a bit-level scoreboard.
// Expected serial bits are queued when a byte is written; a monitor pops one
// per bit_tick seen while busy and compares sout. Inputs change just after the
// falling (active) edge, outputs are sampled on the rising edge.
module tb_pokey_serout;
   import pokey_pkg::*;

   localparam int TICK_PER  = 16;
   localparam int T1_PER    = 4;
   localparam int T2_PER    = 7;
   localparam int LAT_EXP   = 1;
   localparam int BUSY_EXP  = 10 * TICK_PER - 1;

   logic clk = 1'b0;
   logic rst, enn, bit_tick, brk, two_tone, tone1, tone2, sout;

   pokey_serout_if bus_if ();

   pokey_serout dut (
      .clk      (clk),
      .rst      (rst),
      .enn      (enn),
      .bus      (bus_if),
      .bit_tick (bit_tick),
      .brk      (brk),
      .two_tone (two_tone),
      .tone1    (tone1),
      .tone2    (tone2),
      .sout     (sout)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   odn_count = 0;
   int   ticks_seen = 0;
   int   tick_cnt = 0;
   int   t1_cnt = 0;
   int   t2_cnt = 0;
   logic tone_run = 1'b0;
   logic mon_en = 1'b1;
   logic mon_exp;
   logic exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_frame(input logic [7:0] d, input logic brk_on);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(brk_on ? 1'b0 : d[i]);
      exp_q.push_back(brk_on ? 1'b0 : 1'b1);
   endtask

   // Scoreboard monitor: one expected bit per applied tick while busy
   always @(posedge clk) begin
      if (!rst && enn && bus_if.odn) odn_count++;
      if (mon_en && !rst && enn && bit_tick && bus_if.busy) begin
         if (exp_q.size() == 0) begin
            check("sout_unexpected_bit", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sout_bit", {31'd0, sout}, {31'd0, mon_exp});
         end
      end
   end

   // Advance one cycle; drive tick/tone inputs for the next falling edge
   task automatic step();
      @(negedge clk);
      #1;
      bit_tick = (tick_cnt == TICK_PER - 1);
      tick_cnt = (tick_cnt + 1) % TICK_PER;
      tone1    = tone_run && (t1_cnt == T1_PER - 1);
      t1_cnt   = (t1_cnt + 1) % T1_PER;
      tone2    = tone_run && (t2_cnt == T2_PER - 1);
      t2_cnt   = (t2_cnt + 1) % T2_PER;
      if (!rst && enn && bit_tick && bus_if.busy) ticks_seen++;
   endtask

   task automatic write(input logic [7:0] d);
      bus_if.wr = 1'b1;
      bus_if.D  = d;
      step();
      bus_if.wr = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      int k;
      k = 0;
      while (bus_if.busy !== lvl && k < 1000) begin
         step();
         k++;
      end
      check(name, {31'd0, bus_if.busy}, {31'd0, lvl});
   endtask

   // Frame with ticks aligned to the write: latency to busy, and busy length
   task automatic timed_frame(input logic [7:0] d, input logic brk_on,
                              output int lat, output int blen);
      push_frame(d, brk_on);
      tick_cnt = 0;
      write(d);
      lat = 0;
      while (!bus_if.busy && lat < 50) begin
         step();
         lat++;
      end
      check("odn_at_transfer", {31'd0, bus_if.odn}, 32'd1);
      blen = 0;
      while (bus_if.busy && blen < 1000) begin
         step();
         blen++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, blen, base, k;
      int act1, exp1, act2, exp2;
      logic prev, in_data, in_stop, t1, t2;

      rst = 1'b1; enn = 1'b1; brk = 1'b0; two_tone = 1'b0;
      bit_tick = 1'b0; tone1 = 1'b0; tone2 = 1'b0;
      bus_if.wr = 1'b0; bus_if.D = '0;
      step(); step(); step();
      check("rst_sout", {31'd0, sout}, 32'd1);
      check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst_oc", {31'd0, bus_if.oc}, 32'd1);
      check("rst_odn", {31'd0, bus_if.odn}, 32'd0);
      rst = 1'b0;
      step(); step();

      // Single frame A5
      timed_frame(8'hA5, 1'b0, lat, blen);
      check("a5_latency", 32'(lat), 32'(LAT_EXP));
      check("a5_busy_len", 32'(blen), 32'(BUSY_EXP));
      check("a5_oc_after", {31'd0, bus_if.oc}, 32'd1);
      check("a5_queue", 32'(exp_q.size()), 32'd0);
      check("a5_odn_count", 32'(odn_count), 32'd1);
      repeat (40) step();
      check("idle_tick_busy", {31'd0, bus_if.busy}, 32'd0);
      check("idle_tick_sout", {31'd0, sout}, 32'd1);

      // Writes are ignored while the clock enable is low
      enn = 1'b0;
      bus_if.wr = 1'b1;
      bus_if.D  = 8'h42;
      repeat (5) step();
      bus_if.wr = 1'b0;
      check("enn_low_oc", {31'd0, bus_if.oc}, 32'd1);
      enn = 1'b1;
      repeat (5) step();
      check("enn_low_busy", {31'd0, bus_if.busy}, 32'd0);

      // Back-to-back frames 01 then 80
      push_frame(8'h01, 1'b0);
      push_frame(8'h80, 1'b0);
      write(8'h01);
      wait_busy(1'b1, "b2b_start");
      repeat (20) step();
      write(8'h80);
      wait_busy(1'b0, "b2b_end");
      check("b2b_queue", 32'(exp_q.size()), 32'd0);
      check("b2b_odn_count", 32'(odn_count), 32'd3);
      check("b2b_oc", {31'd0, bus_if.oc}, 32'd1);

      // Overwrite 77 with CC, then write 33 on the stop-to-start transfer edge
      push_frame(8'h55, 1'b0);
      push_frame(8'hCC, 1'b0);
      push_frame(8'h33, 1'b0);
      base = ticks_seen;
      write(8'h55);
      wait_busy(1'b1, "coin_start");
      repeat (3) step();
      write(8'h77);
      repeat (3) step();
      write(8'hCC);
      k = 0;
      while ((ticks_seen - base) < 10 && k < 400) begin
         step();
         k++;
      end
      write(8'h33);
      wait_busy(1'b0, "coin_end");
      check("coin_queue", 32'(exp_q.size()), 32'd0);
      check("coin_odn_count", 32'(odn_count), 32'd6);

      // Reset in DATA index 4 with a byte pending
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      base = ticks_seen;
      write(8'hA5);
      wait_busy(1'b1, "abort_start");
      step(); step();
      write(8'h3C);
      k = 0;
      while ((ticks_seen - base) < 5 && k < 400) begin
         step();
         k++;
      end
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_sout", {31'd0, sout}, 32'd1);
      check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
      check("abort_oc", {31'd0, bus_if.oc}, 32'd1);
      check("abort_odn", {31'd0, bus_if.odn}, 32'd0);
      repeat (200) step();
      check("abort_no_odn", 32'(odn_count), 32'd7);
      check("abort_still_idle", {31'd0, bus_if.busy}, 32'd0);
      check("abort_queue", 32'(exp_q.size()), 32'd0);
      push_frame(8'h0F, 1'b0);
      write(8'h0F);
      wait_busy(1'b1, "post_rst_start");
      wait_busy(1'b0, "post_rst_end");
      check("post_rst_queue", 32'(exp_q.size()), 32'd0);
      check("post_rst_odn", 32'(odn_count), 32'd8);

      // Break during a frame of FF: sout low, timing unchanged
      brk = 1'b1;
      step(); step();
      timed_frame(8'hFF, 1'b1, lat, blen);
      check("brk_latency", 32'(lat), 32'(LAT_EXP));
      check("brk_busy_len", 32'(blen), 32'(BUSY_EXP));
      check("brk_queue", 32'(exp_q.size()), 32'd0);
      check("brk_odn_count", 32'(odn_count), 32'd9);
      check("brk_idle_sout", {31'd0, sout}, 32'd0);
      brk = 1'b0;
      step(); step();
      check("brk_release_sout", {31'd0, sout}, 32'd1);

`ifdef POKEY_TWO_TONE_EN
      // Two-tone: data bits of 00 follow tone2, the stop bit follows tone1
      mon_en   = 1'b0;
      two_tone = 1'b1;
      tone_run = 1'b1;
      act1 = 0; exp1 = 0; act2 = 0; exp2 = 0;
      base = ticks_seen;
      write(8'h00);
      wait_busy(1'b1, "tone_start");
      k = 0;
      while (bus_if.busy && k < 1000) begin
         in_data = ((ticks_seen - base) >= 1) && ((ticks_seen - base) <= 8) && !bit_tick;
         in_stop = ((ticks_seen - base) == 9) && !bit_tick;
         t1   = tone1;
         t2   = tone2;
         prev = sout;
         step();
         k++;
         if (in_data) begin
            exp2 += int'(t2);
            act2 += int'(sout != prev);
         end
         if (in_stop) begin
            exp1 += int'(t1);
            act1 += int'(sout != prev);
         end
      end
      check("tone_data_toggles", 32'(act2), 32'(exp2));
      check("tone_stop_toggles", 32'(act1), 32'(exp1));
      check("tone_odn_count", 32'(odn_count), 32'd10);
      two_tone = 1'b0;
      tone_run = 1'b0;
      step(); step();
      mon_en = 1'b1;
`else
      // Two-tone inputs have no effect in this build
      two_tone = 1'b1;
      tone_run = 1'b1;
      push_frame(8'h5A, 1'b0);
      write(8'h5A);
      wait_busy(1'b1, "tone_ign_start");
      wait_busy(1'b0, "tone_ign_end");
      check("tone_ign_queue", 32'(exp_q.size()), 32'd0);
      check("tone_ign_odn", 32'(odn_count), 32'd10);
      repeat (10) step();
      check("tone_ign_idle_sout", {31'd0, sout}, 32'd1);
      two_tone = 1'b0;
      tone_run = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
